// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive FCS checker.
// Holds the reflected CRC-32 parameters, the length counter width and the receive FSM state type.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam int              LEN_W   = 12;
  localparam logic [LEN_W-1:0] LEN_SAT = '1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } rx_state_t;

  // Byte counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] len);
    return (len == LEN_SAT) ? len : len + 1'b1;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte update of a reflected CRC-32 register.
// The byte is consumed LSB first, matching Ethernet wire order.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive-side FCS checker: strips the trailing 4-byte FCS through a delay line,
// checks the CRC residue and frame length, and reports a one-cycle status strobe per frame.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             st_valid,
  output logic             st_crc_err,
  output logic             st_len_err,
  output logic [LEN_W-1:0] st_len
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [31:0]      crc;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] len_next;
  logic [3:0][7:0]  dly;
  logic             emit;

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data    (s_data),
    .crc_out (crc_next)
  );

  assign len_next = len_inc(count);
  // Once four bytes are buffered, every new byte pushes the oldest one out as payload.
  assign emit     = s_valid && (state == STREAM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s_valid) begin
          state_next = s_last ? IDLE : FILL;
        end
      end
      FILL: begin
        if (s_valid) begin
          if (s_last) begin
            state_next = IDLE;
          end else if (count == LEN_W'(3)) begin
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (s_valid && s_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A frame ending before STREAM is at most 4 bytes long and cannot carry a valid FCS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc        <= CRC32_INIT;
      count      <= '0;
      dly        <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      st_valid   <= 1'b0;
      st_crc_err <= 1'b0;
      st_len_err <= 1'b0;
      st_len     <= '0;
    end else begin
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      st_valid <= 1'b0;
      if (s_valid) begin
        dly <= {dly[2:0], s_data};
        if (emit) begin
          m_valid <= 1'b1;
          m_data  <= dly[3];
          m_last  <= s_last;
        end
        if (s_last) begin
          st_valid   <= 1'b1;
          st_len     <= len_next;
          st_len_err <= (len_next < MIN_L) || (len_next > MAX_L);
          st_crc_err <= (state != STREAM) || (crc_next != CRC32_RESIDUE);
          crc        <= CRC32_INIT;
          count      <= '0;
        end else begin
          crc   <= crc_next;
          count <= len_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Self-checking bench for eth_rx_fcs_check: randomized frames against a frame-level reference
// model (standard CRC-32 of the payload compared with the transmitted FCS), plus literal checks.
module tb_eth_rx_fcs_check;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        st_valid;
  logic        st_crc_err;
  logic        st_len_err;
  logic [11:0] st_len;

  int checks = 0;
  int errors = 0;

  logic [7:0]  obs_pay[$];
  logic [11:0] obs_len[$];
  logic        obs_crc[$];
  logic        obs_lerr[$];
  int          obs_mlast = 0;
  logic [7:0]  mdl_fr[$];

  always #5 clk = ~clk;

  eth_rx_fcs_check #(
    .MAX_LEN (1518),
    .MIN_LEN (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .st_valid   (st_valid),
    .st_crc_err (st_crc_err),
    .st_len_err (st_len_err),
    .st_len     (st_len)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-serial IEEE CRC-32 over the first n bytes, with the final inversion applied.
  function automatic logic [31:0] crc32_std(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic logic fcs_ok(input bq_t fr);
    int n;
    n = fr.size();
    if (n < 5) return 1'b0;
    return {fr[n-1], fr[n-2], fr[n-3], fr[n-4]} == crc32_std(fr, n - 4);
  endfunction

  function automatic bq_t make_frame(input int pay_len, input logic corrupt);
    bq_t         fr;
    logic [31:0] fcs;
    int          idx;
    for (int i = 0; i < pay_len; i++) fr.push_back(8'($urandom));
    fcs = crc32_std(fr, pay_len);
    fr.push_back(fcs[7:0]);
    fr.push_back(fcs[15:8]);
    fr.push_back(fcs[23:16]);
    fr.push_back(fcs[31:24]);
    if (corrupt) begin
      idx = $urandom_range(fr.size() - 1);
      fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(7));
    end
    return fr;
  endfunction

  task automatic applyStimulus(input bq_t fr, input int gap_pct, input int stop_after);
    int n;
    n = (stop_after > 0) ? stop_after : fr.size();
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = fr[i];
      s_last  = (stop_after == 0) && (i == n - 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_pay.delete();
    obs_len.delete();
    obs_crc.delete();
    obs_lerr.delete();
    obs_mlast = 0;
  endtask

  // Frame-level reference: on each accepted byte the output is the byte four positions back.
  initial begin : compare_proc
    logic        cv, cl, cr;
    logic [7:0]  cd;
    int          n;
    logic        e_mv, e_ml, e_sv, e_ce, e_le;
    logic [7:0]  e_md;
    logic [11:0] e_len;
    forever begin
      @(posedge clk);
      cv = s_valid;
      cl = s_last;
      cd = s_data;
      cr = rst;
      #1;
      e_mv = 1'b0; e_ml = 1'b0; e_sv = 1'b0; e_ce = 1'b0; e_le = 1'b0;
      e_md = 8'h00; e_len = 12'h000;
      if (cr || rst) begin
        mdl_fr.delete();
      end else if (cv) begin
        mdl_fr.push_back(cd);
        n = mdl_fr.size();
        if (n >= 5) begin
          e_mv = 1'b1;
          e_md = mdl_fr[n-5];
          e_ml = cl;
        end
        if (cl) begin
          e_sv  = 1'b1;
          e_len = (n > 4095) ? 12'd4095 : 12'(n);
          e_le  = (n < 64) || (n > 1518);
          e_ce  = !fcs_ok(mdl_fr);
          mdl_fr.delete();
        end
      end
      checkOutput("m_valid", 32'(m_valid), 32'(e_mv));
      checkOutput("m_last", 32'(m_last), 32'(e_ml));
      checkOutput("st_valid", 32'(st_valid), 32'(e_sv));
      if (e_mv) checkOutput("m_data", 32'(m_data), 32'(e_md));
      if (e_sv) begin
        checkOutput("st_len", 32'(st_len), 32'(e_len));
        checkOutput("st_crc_err", 32'(st_crc_err), 32'(e_ce));
        checkOutput("st_len_err", 32'(st_len_err), 32'(e_le));
      end
      if (m_valid) obs_pay.push_back(m_data);
      if (m_valid && m_last) obs_mlast++;
      if (st_valid) begin
        obs_len.push_back(st_len);
        obs_crc.push_back(st_crc_err);
        obs_lerr.push_back(st_len_err);
      end
    end
  end

  initial begin : main_proc
    bq_t f29, f30, fa, fb;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_m_data", 32'(m_data), 32'h0);
    checkOutput("reset_st_len", 32'(st_len), 32'h0);
    checkOutput("reset_st_flags", 32'({st_crc_err, st_len_err}), 32'h0);
    rst = 1'b0;
    idle(2);

    f29 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    checkOutput("model_crc_check_string", crc32_std(f29, 9), 32'hCBF43926);

    clear_obs();
    applyStimulus(f29, 0, 0);
    idle(4);
    checkOutput("t29_pay_count", 32'(obs_pay.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < obs_pay.size()) checkOutput("t29_pay", 32'(obs_pay[i]), 32'h31 + 32'(i));
    checkOutput("t29_m_last_count", 32'(obs_mlast), 32'd1);
    checkOutput("t29_st_count", 32'(obs_len.size()), 32'd1);
    if (obs_len.size() == 1) begin
      checkOutput("t29_st_len", 32'(obs_len[0]), 32'd13);
      checkOutput("t29_crc_err", 32'(obs_crc[0]), 32'd0);
      checkOutput("t29_len_err", 32'(obs_lerr[0]), 32'd1);
    end

    f30 = f29;
    f30[12] = 8'hCA;
    clear_obs();
    applyStimulus(f30, 20, 0);
    idle(4);
    checkOutput("t30_pay_count", 32'(obs_pay.size()), 32'd9);
    checkOutput("t30_st_count", 32'(obs_crc.size()), 32'd1);
    if (obs_crc.size() == 1) checkOutput("t30_crc_err", 32'(obs_crc[0]), 32'd1);

    fa = make_frame(60, 1'b0);
    clear_obs();
    applyStimulus(fa, 30, 0);
    idle(4);
    checkOutput("t64_pay_count", 32'(obs_pay.size()), 32'd60);
    for (int i = 0; i < 60; i++)
      if (i < obs_pay.size()) checkOutput("t64_pay", 32'(obs_pay[i]), 32'(fa[i]));
    if (obs_len.size() == 1) begin
      checkOutput("t64_st_len", 32'(obs_len[0]), 32'd64);
      checkOutput("t64_crc_err", 32'(obs_crc[0]), 32'd0);
      checkOutput("t64_len_err", 32'(obs_lerr[0]), 32'd0);
    end else checkOutput("t64_st_count", 32'(obs_len.size()), 32'd1);

    fa = {8'hA5, 8'h5A, 8'h3C};
    clear_obs();
    applyStimulus(fa, 0, 0);
    idle(4);
    checkOutput("t3_pay_count", 32'(obs_pay.size()), 32'd0);
    if (obs_len.size() == 1) begin
      checkOutput("t3_st_len", 32'(obs_len[0]), 32'd3);
      checkOutput("t3_len_err", 32'(obs_lerr[0]), 32'd1);
      checkOutput("t3_crc_err", 32'(obs_crc[0]), 32'd1);
    end else checkOutput("t3_st_count", 32'(obs_len.size()), 32'd1);

    fa = make_frame($urandom_range(60, 80), 1'b0);
    fb = make_frame($urandom_range(60, 80), 1'b0);
    clear_obs();
    applyStimulus(fa, 0, 0);
    applyStimulus(fb, 0, 0);
    idle(4);
    checkOutput("b2b_m_last_count", 32'(obs_mlast), 32'd2);
    checkOutput("b2b_st_count", 32'(obs_crc.size()), 32'd2);
    if (obs_crc.size() == 2) checkOutput("b2b_crc_errs", 32'({obs_crc[0], obs_crc[1]}), 32'd0);

    fa = make_frame(60, 1'b0);
    clear_obs();
    applyStimulus(fa, 10, 20);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    fb = make_frame(60, 1'b0);
    applyStimulus(fb, 10, 0);
    idle(4);
    checkOutput("rst_m_last_count", 32'(obs_mlast), 32'd1);
    if (obs_crc.size() == 1) begin
      checkOutput("rst_crc_err", 32'(obs_crc[0]), 32'd0);
      checkOutput("rst_st_len", 32'(obs_len[0]), 32'd64);
    end else checkOutput("rst_st_count", 32'(obs_crc.size()), 32'd1);

    for (int f = 0; f < 20; f++) begin
      fa = make_frame($urandom_range(0, 110), 1'($urandom_range(3) == 0));
      if ($urandom_range(4) == 0) fa = fa[0:$urandom_range(3)];
      applyStimulus(fa, $urandom_range(40), 0);
      if ($urandom_range(1) == 0) idle($urandom_range(3));
    end
    idle(4);

    fa = make_frame(1596, 1'b0);
    clear_obs();
    applyStimulus(fa, 0, 0);
    idle(4);
    if (obs_len.size() == 1) begin
      checkOutput("big_st_len", 32'(obs_len[0]), 32'd1600);
      checkOutput("big_len_err", 32'(obs_lerr[0]), 32'd1);
      checkOutput("big_crc_err", 32'(obs_crc[0]), 32'd0);
    end else checkOutput("big_st_count", 32'(obs_len.size()), 32'd1);

    fa = make_frame(4096, 1'b0);
    clear_obs();
    applyStimulus(fa, 0, 0);
    idle(4);
    checkOutput("sat_pay_count", 32'(obs_pay.size()), 32'd4096);
    if (obs_len.size() == 1) begin
      checkOutput("sat_st_len", 32'(obs_len[0]), 32'd4095);
      checkOutput("sat_len_err", 32'(obs_lerr[0]), 32'd1);
      checkOutput("sat_crc_err", 32'(obs_crc[0]), 32'd0);
    end else checkOutput("sat_st_count", 32'(obs_len.size()), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
